slave_port_arbiter: RTL and testbench
=====================================

SLAVE_PORT_ARBITER -- requirements
Module: slave_port_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port m0_in, input, 32 bits (integer, signed): data offered by requester 0.
REQ-004 SHALL have port m0_in_sync, input, 1 bit: requester 0 has valid data on m0_in.
REQ-005 SHALL have port m1_in, input, 32 bits (integer, signed): data offered by requester 1.
REQ-006 SHALL have port m1_in_sync, input, 1 bit: requester 1 has valid data on m1_in.
REQ-007 SHALL have port m0_ack, output, 1 bit: one-cycle pulse when requester 0 data is captured.
REQ-008 SHALL have port m1_ack, output, 1 bit: one-cycle pulse when requester 1 data is captured.
REQ-009 SHALL have port s_out, output, 32 bits (integer, signed): data to the shared downstream slave.
REQ-010 SHALL have port s_out_notify, output, 1 bit: s_out valid, held until accepted.
REQ-011 SHALL have port s_out_sync, input, 1 bit: downstream accepts s_out this cycle.
REQ-012 SHALL have port txn_count, output, 8 bits (unsigned): completed transfers, modulo 256.

Function
REQ-013 SHALL implement a state machine over the states SEC_IDLE, SEC_SERVE0 and SEC_SERVE1.
REQ-014 SHALL, in SEC_IDLE with exactly one sync high at edge T, latch that requester's data into s_out and enter SEC_SERVEn at T+1.
REQ-015 SHALL, at T+1, assert the matching mN_ack for exactly one cycle and assert s_out_notify.
REQ-016 SHALL resolve the case where both syncs are high in SEC_IDLE by round-robin: grant the requester not granted last.
REQ-017 SHALL keep a last-grant pointer that updates on each capture.
REQ-018 SHALL hold s_out and s_out_notify stable in SEC_SERVEn until s_out_sync is sampled high.
REQ-019 SHALL, on the edge where s_out_sync is sampled high, go to SEC_IDLE, deassert s_out_notify, increment txn_count with wrap 255->0, and keep s_out at its last value.
REQ-020 SHALL ignore both request syncs outside SEC_IDLE; those requesters stay pending with no ack.
REQ-021 SHALL capture no data on the accept edge; the minimum spacing between captures is one SEC_IDLE cycle.
REQ-022 SHALL ignore s_out_sync while in SEC_IDLE.
REQ-023 SHALL pass data unmodified with no width change.

Reset
REQ-024 SHALL, while rst is low and independent of clk, force: state SEC_IDLE, s_out 0, s_out_notify 0, m0_ack 0, m1_ack 0, txn_count 0, last-grant pointer = 1.
REQ-025 SHALL, on reset during SEC_SERVEn, abandon the in-flight transfer with no count increment and no ack re-issue.
REQ-026 SHALL, with the pointer at 1 after reset, grant requester 0 on the first tie.

Configuration
REQ-027 SHALL, with macro SLAVE_PORT_ARB_FIXED_PRIO_EN defined, resolve ties as fixed priority: requester 0 always wins and the pointer is unused.
REQ-028 SHALL, without SLAVE_PORT_ARB_FIXED_PRIO_EN, resolve ties by round-robin per REQ-016; all other behaviour is identical in both builds.

Verification
REQ-029 SHALL cover single request: m0_in=5, m0_in_sync=1 at T in SEC_IDLE -> m0_ack=1 and s_out_notify=1 with s_out=5 at T+1; m0_ack=0 at T+2.
REQ-030 SHALL cover tie after reset: m0=10 and m1=20 both synced -> first grant m0 (s_out=10); after accept, second grant m1 (s_out=20); txn_count=2.
REQ-031 SHALL cover back-pressure: s_out_sync held low 4 cycles after grant -> s_out and s_out_notify stable for 4 cycles; 1 cycle after s_out_sync=1, notify=0 and txn_count increments.
REQ-032 SHALL cover wrap: 256 accepted transfers -> txn_count returns to 0.
REQ-033 SHALL cover mid-transfer reset: rst low during SEC_SERVE1 -> all outputs 0 immediately with no clk edge; txn_count unchanged from 0.
REQ-034 SHALL cover fixed-priority build: persistent tie over 3 transfers -> all 3 granted to requester 0.

Source files
------------

// File: rtl/slave_port_arbiter.sv
// Two-requester arbiter feeding one downstream slave with a held-until-accepted handshake.
// Optional build macro SLAVE_PORT_ARB_FIXED_PRIO_EN: ties go to requester 0 instead of round-robin.
module slave_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_in,
    input  logic        m0_in_sync,
    input  logic [31:0] m1_in,
    input  logic        m1_in_sync,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] s_out,
    output logic        s_out_notify,
    input  logic        s_out_sync,
    output logic [7:0]  txn_count
);

    typedef enum logic [1:0] {
        SecIdle   = 2'd0,
        SecServe0 = 2'd1,
        SecServe1 = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] s_out_q, s_out_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic [7:0]  txn_q, txn_d;
    logic        last_q, last_d;
    logic        grant_valid;
    logic        grant1;

    always_comb begin
        state_d     = state_q;
        s_out_d     = s_out_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        txn_d       = txn_q;
        last_d      = last_q;
        grant_valid = 1'b0;
        grant1      = 1'b0;

        unique case (state_q)
            SecIdle: begin
                if (m0_in_sync && m1_in_sync) begin
                    grant_valid = 1'b1;
`ifdef SLAVE_PORT_ARB_FIXED_PRIO_EN
                    grant1      = 1'b0;
`else
                    // last_q holds the previous winner, so a tie goes to the other one
                    grant1      = ~last_q;
`endif
                end else if (m0_in_sync) begin
                    grant_valid = 1'b1;
                    grant1      = 1'b0;
                end else if (m1_in_sync) begin
                    grant_valid = 1'b1;
                    grant1      = 1'b1;
                end

                if (grant_valid) begin
                    s_out_d  = grant1 ? m1_in : m0_in;
                    state_d  = grant1 ? SecServe1 : SecServe0;
                    m0_ack_d = ~grant1;
                    m1_ack_d = grant1;
                    last_d   = grant1;
                end
            end
            SecServe0, SecServe1: begin
                // Requests are ignored here; the accept edge never captures new data
                if (s_out_sync) begin
                    state_d = SecIdle;
                    txn_d   = txn_q + 8'd1;
                end
            end
            default: begin
                state_d = SecIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SecIdle;
            s_out_q  <= 32'd0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            txn_q    <= 8'd0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            s_out_q  <= s_out_d;
            m0_ack_q <= m0_ack_d;
            m1_ack_q <= m1_ack_d;
            txn_q    <= txn_d;
            last_q   <= last_d;
        end
    end

    assign s_out        = s_out_q;
    assign s_out_notify = (state_q != SecIdle);
    assign m0_ack       = m0_ack_q;
    assign m1_ack       = m1_ack_q;
    assign txn_count    = txn_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Bench for slave_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model. Define SLAVE_PORT_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_slave_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m0_in = 32'd0;
    logic        m0_in_sync = 1'b0;
    logic [31:0] m1_in = 32'd0;
    logic        m1_in_sync = 1'b0;
    logic        s_out_sync = 1'b0;
    logic        m0_ack;
    logic        m1_ack;
    logic [31:0] s_out;
    logic        s_out_notify;
    logic [7:0]  txn_count;

    int tests = 0;
    int fails = 0;

    // Reference model: "is a transfer outstanding", its data, who won last, how many completed
    bit          mb;
    logic [31:0] mdata;
    bit          mack0, mack1;
    int          mcnt;
    int          mlast;

    slave_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .m0_in        (m0_in),
        .m0_in_sync   (m0_in_sync),
        .m1_in        (m1_in),
        .m1_in_sync   (m1_in_sync),
        .m0_ack       (m0_ack),
        .m1_ack       (m1_ack),
        .s_out        (s_out),
        .s_out_notify (s_out_notify),
        .s_out_sync   (s_out_sync),
        .txn_count    (txn_count)
    );

    always #5 clk = ~clk;

    function automatic int tie_winner(input int last);
`ifdef SLAVE_PORT_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last == 0) ? 1 : 0;
`endif
    endfunction

    function void model_reset();
        mb = 0; mdata = 32'd0; mack0 = 0; mack1 = 0; mcnt = 0; mlast = 1;
    endfunction

    function void model_step();
        int g;
        mack0 = 0;
        mack1 = 0;
        if (!mb) begin
            g = -1;
            if (m0_in_sync && m1_in_sync) g = tie_winner(mlast);
            else if (m0_in_sync)          g = 0;
            else if (m1_in_sync)          g = 1;
            if (g >= 0) begin
                mb    = 1;
                mdata = (g == 1) ? m1_in : m0_in;
                mack0 = (g == 0);
                mack1 = (g == 1);
                mlast = g;
            end
        end else if (s_out_sync) begin
            mb   = 0;
            mcnt = (mcnt + 1) % 256;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #2;
        tests++;
        if ({s_out, s_out_notify, m0_ack, m1_ack, txn_count} !== {32'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL reset_values got s_out=%0d notify=%b ack0=%b ack1=%b cnt=%0d want all 0",
                     s_out, s_out_notify, m0_ack, m1_ack, txn_count);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tests++;
        if ({s_out_notify, m0_ack, m1_ack, txn_count} !== 11'd0) begin
            fails++;
            $display("FAIL reset_idle got notify=%b ack0=%b ack1=%b cnt=%0d want 0",
                     s_out_notify, m0_ack, m1_ack, txn_count);
        end
    endtask

    task automatic test_single();
        m0_in = 32'd5;
        m0_in_sync = 1'b1;
        tick();
        tests++;
        if ({m0_ack, m1_ack, s_out_notify, s_out} !== {1'b1, 1'b0, 1'b1, 32'd5}) begin
            fails++;
            $display("FAIL single_grant got ack0=%b ack1=%b notify=%b s_out=%0d want 1 0 1 5",
                     m0_ack, m1_ack, s_out_notify, s_out);
        end
        m0_in_sync = 1'b0;
        tick();
        tests++;
        if ({m0_ack, s_out_notify, s_out} !== {1'b0, 1'b1, 32'd5}) begin
            fails++;
            $display("FAIL single_ack_pulse got ack0=%b notify=%b s_out=%0d want 0 1 5",
                     m0_ack, s_out_notify, s_out);
        end
        s_out_sync = 1'b1;
        tick();
        s_out_sync = 1'b0;
        tests++;
        if ({s_out_notify, s_out, txn_count} !== {1'b0, 32'd5, mcnt[7:0]}) begin
            fails++;
            $display("FAIL single_accept got notify=%b s_out=%0d cnt=%0d want 0 5 %0d",
                     s_out_notify, s_out, txn_count, mcnt);
        end
    endtask

    task automatic test_tie();
        logic [31:0] second;
`ifdef SLAVE_PORT_ARB_FIXED_PRIO_EN
        second = 32'd10;
`else
        second = 32'd20;
`endif
        apply_reset();
        m0_in = 32'd10; m1_in = 32'd20;
        m0_in_sync = 1'b1; m1_in_sync = 1'b1;
        tick();
        tests++;
        if ({s_out, m0_ack, m1_ack, s_out_notify} !== {32'd10, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL tie_first got s_out=%0d ack0=%b ack1=%b want 10 1 0", s_out, m0_ack, m1_ack);
        end
        s_out_sync = 1'b1;
        tick();
        s_out_sync = 1'b0;
        tests++;
        if ({s_out_notify, txn_count} !== {1'b0, 8'd1}) begin
            fails++;
            $display("FAIL tie_accept1 got notify=%b cnt=%0d want 0 1", s_out_notify, txn_count);
        end
        tick();
        tests++;
        if ({s_out, s_out_notify} !== {second, 1'b1} || m1_ack !== (second == 32'd20)) begin
            fails++;
            $display("FAIL tie_second got s_out=%0d ack1=%b want s_out=%0d", s_out, m1_ack, second);
        end
        m0_in_sync = 1'b0; m1_in_sync = 1'b0;
        s_out_sync = 1'b1;
        tick();
        s_out_sync = 1'b0;
        tests++;
        if ({s_out_notify, txn_count, s_out} !== {1'b0, 8'd2, second}) begin
            fails++;
            $display("FAIL tie_count got notify=%b cnt=%0d s_out=%0d want 0 2 %0d",
                     s_out_notify, txn_count, s_out, second);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        int cnt0;
        d = $urandom;
        cnt0 = mcnt;
        m1_in = d;
        m1_in_sync = 1'b1;
        tick();
        m1_in_sync = 1'b0;
        tests++;
        if ({s_out, s_out_notify, m1_ack} !== {d, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL bp_grant got s_out=%h notify=%b ack1=%b want %h 1 1", s_out, s_out_notify, m1_ack, d);
        end
        for (int i = 0; i < 4; i++) begin
            m1_in = $urandom;
            m0_in_sync = 1'(i[0]);
            tick();
            tests++;
            if ({s_out, s_out_notify, m0_ack, m1_ack} !== {d, 1'b1, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold[%0d] got s_out=%h notify=%b ack0=%b ack1=%b want %h 1 0 0",
                         i, s_out, s_out_notify, m0_ack, m1_ack, d);
            end
        end
        m0_in_sync = 1'b0;
        s_out_sync = 1'b1;
        tick();
        s_out_sync = 1'b0;
        tests++;
        if ({s_out_notify, s_out, txn_count} !== {1'b0, d, 8'((cnt0 + 1) % 256)}) begin
            fails++;
            $display("FAIL bp_accept got notify=%b s_out=%h cnt=%0d want 0 %h %0d",
                     s_out_notify, s_out, txn_count, d, (cnt0 + 1) % 256);
        end
        s_out_sync = 1'b1;
        tick();
        s_out_sync = 1'b0;
        tests++;
        if ({s_out_notify, txn_count} !== {1'b0, 8'((cnt0 + 1) % 256)}) begin
            fails++;
            $display("FAIL bp_idle_sync_ignored got notify=%b cnt=%0d want 0 %0d",
                     s_out_notify, txn_count, (cnt0 + 1) % 256);
        end
    endtask

    task automatic test_persistent_tie();
        int exp_g [3];
`ifdef SLAVE_PORT_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0};
`else
        exp_g = '{0, 1, 0};
`endif
        apply_reset();
        m0_in = 32'hA0A0_0000; m1_in = 32'hB1B1_0001;
        m0_in_sync = 1'b1; m1_in_sync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (m0_ack !== (exp_g[i] == 0) || m1_ack !== (exp_g[i] == 1)) begin
                fails++;
                $display("FAIL persistent_tie[%0d] got ack0=%b ack1=%b want winner %0d",
                         i, m0_ack, m1_ack, exp_g[i]);
            end
            s_out_sync = 1'b1;
            tick();
            s_out_sync = 1'b0;
        end
        m0_in_sync = 1'b0; m1_in_sync = 1'b0;
        tests++;
        if (txn_count !== 8'd3) begin
            fails++;
            $display("FAIL persistent_tie_count got %0d want 3", txn_count);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            m0_in      = $urandom;
            m1_in      = $urandom;
            m0_in_sync = ($urandom_range(0, 99) < 50);
            m1_in_sync = ($urandom_range(0, 99) < 50);
            s_out_sync = ($urandom_range(0, 99) < 35);
            tick();
            tests++;
            if ({s_out, s_out_notify, m0_ack, m1_ack, txn_count} !==
                {mdata, mb, mack0, mack1, mcnt[7:0]}) begin
                fails++;
                $display("FAIL random[%0d] got s_out=%h n=%b a0=%b a1=%b c=%0d want %h %b %b %b %0d",
                         i, s_out, s_out_notify, m0_ack, m1_ack, txn_count,
                         mdata, mb, mack0, mack1, mcnt);
            end
        end
        m0_in_sync = 1'b0; m1_in_sync = 1'b0; s_out_sync = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            m0_in = i;
            m0_in_sync = 1'b1;
            tick();
            m0_in_sync = 1'b0;
            s_out_sync = 1'b1;
            tick();
            s_out_sync = 1'b0;
            tests++;
            if ({s_out, s_out_notify, txn_count} !== {mdata, mb, mcnt[7:0]}) begin
                fails++;
                $display("FAIL wrap[%0d] got s_out=%0d notify=%b cnt=%0d want %0d %b %0d",
                         i, s_out, s_out_notify, txn_count, mdata, mb, mcnt);
            end
        end
        tests++;
        if (txn_count !== 8'd0) begin
            fails++;
            $display("FAIL wrap_zero got cnt=%0d want 0", txn_count);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        m1_in = 32'h1234_5678;
        m1_in_sync = 1'b1;
        tick();
        m1_in_sync = 1'b0;
        tests++;
        if ({s_out_notify, m1_ack, s_out} !== {1'b1, 1'b1, 32'h1234_5678}) begin
            fails++;
            $display("FAIL midrst_grant got notify=%b ack1=%b s_out=%h want 1 1 12345678",
                     s_out_notify, m1_ack, s_out);
        end
        tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({s_out, s_out_notify, m0_ack, m1_ack, txn_count} !== {32'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL midrst_async got s_out=%h notify=%b ack0=%b ack1=%b cnt=%0d want all 0",
                     s_out, s_out_notify, m0_ack, m1_ack, txn_count);
        end
        @(negedge clk);
        rst = 1'b1;
        s_out_sync = 1'b1;
        tick();
        tick();
        s_out_sync = 1'b0;
        tests++;
        if ({s_out_notify, m0_ack, m1_ack, txn_count} !== 11'd0) begin
            fails++;
            $display("FAIL midrst_after got notify=%b ack0=%b ack1=%b cnt=%0d want 0",
                     s_out_notify, m0_ack, m1_ack, txn_count);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_persistent_tie();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
